// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Sequences the UART receiver and assembles its byte stream into command
//   frames of the form SOF, LEN, LEN payload bytes, CSUM, where CSUM is the
//   XOR of LEN and every payload byte. A good frame is held and offered on a
//   valid/ready port. Bad, broken, disabled or stalled frames are dropped,
//   and the drop is flagged with a one-cycle error pulse where applicable.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   enable        receive enable; uart_rx_en is its registered copy
//   rx_valid      1-cycle byte strobe from uart_rx, with rx_data / rx_break
//   frame_valid   a complete good frame is held
//   frame_ready   consumer accepts the held frame
//   frame_len     payload length of the held frame
//   frame_data    payload, byte k at [8k+7:8k]; bytes at or above LEN read 0
//   err_crc       checksum mismatch pulse
//   err_len       LEN == 0 or LEN > MAX_LEN pulse
//   err_timeout   inter-byte timeout pulse
//   err_overrun   byte arrived while a frame was held (byte dropped)
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF            = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 uart_rx_en,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 rx_break,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [3:0]           frame_len,
  output logic [8*MAX_LEN-1:0] frame_data,
  output logic                 err_crc,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;   // cycles since entry to LEN or since the last byte
  logic [7:0]    acc;   // running XOR of LEN and payload bytes
  logic [3:0]    idx;   // next payload byte slot

  // Frame sequencer: state, counters, held frame and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= 8'h00;
      idx         <= 4'd0;
      uart_rx_en  <= 1'b0;
      frame_valid <= 1'b0;
      frame_len   <= 4'd0;
      frame_data  <= '0;
      err_crc     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      uart_rx_en  <= enable;
      err_crc     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (enable && rx_valid && !rx_break && (rx_data == SOF)) begin
            state      <= S_LEN;
            frame_data <= '0;
            acc        <= 8'h00;
            idx        <= 4'd0;
          end
        end

        S_LEN, S_PAYLOAD, S_CSUM: begin
          if (!enable) begin
            // Disabling mid-frame abandons it without an error.
            state <= S_IDLE;
            cnt   <= '0;
          end else if (rx_valid) begin
            // A byte always beats a timeout landing in the same cycle.
            cnt <= '0;
            if (rx_break) begin
              state <= S_IDLE;
            end else if (state == S_LEN) begin
              if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
                err_len <= 1'b1;
                state   <= S_IDLE;
              end else begin
                frame_len <= rx_data[3:0];
                acc       <= rx_data;
                state     <= S_PAYLOAD;
              end
            end else if (state == S_PAYLOAD) begin
              for (int k = 0; k < MAX_LEN; k++) begin
                if (idx == 4'(k)) begin
                  frame_data[8*k +: 8] <= rx_data;
                end
              end
              acc <= acc ^ rx_data;
              idx <= idx + 4'd1;
              if (idx == (frame_len - 4'd1)) begin
                state <= S_CSUM;
              end
            end else begin
              if (rx_data == acc) begin
                frame_valid <= 1'b1;
                state       <= S_HOLD;
              end else begin
                err_crc <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end else if (cnt == TERM) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_HOLD: begin
          // Any byte here is lost, including on the accept cycle.
          if (rx_valid) begin
            err_overrun <= 1'b1;
          end
          if (frame_ready) begin
            frame_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          state       <= S_IDLE;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         MAX_LEN = 8;
  localparam int         TO      = 16;

  logic        clk = 1'b0;
  logic        reset, enable, rx_valid, rx_break, frame_ready;
  logic [7:0]  rx_data;
  logic        uart_rx_en, frame_valid, err_crc, err_len, err_timeout, err_overrun;
  logic [3:0]  frame_len;
  logic [63:0] frame_data;

  uart_rx_frame_ctrl #(.SOF(SOF), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .uart_rx_en(uart_rx_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_len(frame_len), .frame_data(frame_data),
    .err_crc(err_crc), .err_len(err_len), .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes of the current frame kept in a queue, timing by
  // cycle timestamps, held frame as plain variables.
  logic [7:0]  q[$];
  bit          m_coll = 1'b0;
  bit          m_held = 1'b0;
  longint      cyc = 0;
  longint      last_ts = 0;
  logic [3:0]  m_len = 4'd0;
  logic [63:0] m_data = 64'd0;
  logic        e_en = 1'b0, e_crc = 1'b0, e_lenerr = 1'b0, e_to = 1'b0, e_ovr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int         n, len;
    logic [7:0] x;
    e_crc = 1'b0; e_lenerr = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
    if (reset) begin
      e_en = 1'b0; m_coll = 1'b0; m_held = 1'b0; m_len = 4'd0; m_data = 64'd0;
      q.delete();
    end else begin
      e_en = enable;
      if (m_held) begin
        if (rx_valid) e_ovr = 1'b1;
        if (frame_ready) m_held = 1'b0;
      end else if (!m_coll) begin
        if (enable && rx_valid && !rx_break && rx_data == SOF) begin
          m_coll = 1'b1; q.delete(); m_data = 64'd0; last_ts = cyc;
        end
      end else if (!enable) begin
        m_coll = 1'b0;
      end else if (rx_valid) begin
        last_ts = cyc;
        if (rx_break) m_coll = 1'b0;
        else begin
          q.push_back(rx_data);
          n   = q.size();
          len = int'(q[0]);
          if (n == 1) begin
            if (len == 0 || len > MAX_LEN) begin e_lenerr = 1'b1; m_coll = 1'b0; end
            else m_len = q[0][3:0];
          end else if (n <= len + 1) begin
            m_data[8*(n-2) +: 8] = rx_data;
          end else begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x ^= q[i];
            if (rx_data == x) m_held = 1'b1;
            else e_crc = 1'b1;
            m_coll = 1'b0;
          end
        end
      end else if (cyc - last_ts == longint'(TO)) begin
        e_to = 1'b1; m_coll = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("uart_rx_en", uart_rx_en, e_en);
    chk("frame_valid", frame_valid, m_held);
    chk("frame_len", frame_len, m_len);
    chk("frame_data", frame_data, m_data);
    chk("err_crc", err_crc, e_crc);
    chk("err_len", err_len, e_lenerr);
    chk("err_timeout", err_timeout, e_to);
    chk("err_overrun", err_overrun, e_ovr);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_good_frame();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
  endtask

  typedef struct {
    int          nb;
    logic [95:0] seq;   // first byte in the most significant used position
    int          kind;  // 0 good, 1 checksum error, 2 length error
    logic [3:0]  len;
    logic [63:0] data;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] b;
    int         len, gap;
    logic [7:0] frm[$];
    logic [7:0] x;

    tbl[0] = '{6,  96'hA5_03_11_22_33_03,          0, 4'd3, 64'h332211};
    tbl[1] = '{6,  96'hA5_03_11_22_33_04,          1, 4'd0, 64'h0};
    tbl[2] = '{4,  96'h00_FF_A5_00,                2, 4'd0, 64'h0};
    tbl[3] = '{2,  96'hA5_09,                      2, 4'd0, 64'h0};
    tbl[4] = '{4,  96'hA5_01_7E_7F,                0, 4'd1, 64'h7E};
    tbl[5] = '{11, 96'hA5_08_01_02_03_04_05_06_07_08_00, 0, 4'd8, 64'h0807060504030201};
    tbl[6] = '{2,  96'hA5_A5,                      2, 4'd0, 64'h0};
    tbl[7] = '{5,  96'hA5_02_A5_5A_FD,             0, 4'd2, 64'h5AA5};

    reset = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rx_break = 1'b0; frame_ready = 1'b0;
    idle(2);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_data", frame_data, 64'd0);
    chk("rst_uart_rx_en", uart_rx_en, 1'b0);
    reset = 1'b0; enable = 1'b1;
    tick();
    chk("uart_rx_en_follow", uart_rx_en, 1'b1);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < tbl[v].nb; i++) begin
        b = tbl[v].seq[8*(tbl[v].nb-1-i) +: 8];
        send(b);
      end
      chk($sformatf("tbl%0d_valid", v), frame_valid, tbl[v].kind == 0);
      chk($sformatf("tbl%0d_crc", v), err_crc, tbl[v].kind == 1);
      chk($sformatf("tbl%0d_len", v), err_len, tbl[v].kind == 2);
      if (tbl[v].kind == 0) begin
        chk($sformatf("tbl%0d_flen", v), frame_len, tbl[v].len);
        chk($sformatf("tbl%0d_fdata", v), frame_data, tbl[v].data);
      end
      idle(1);
      chk($sformatf("tbl%0d_pulse_end", v), err_crc | err_len, 1'b0);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      chk($sformatf("tbl%0d_released", v), frame_valid, 1'b0);
    end

    // Timeout at exactly the terminal count.
    send(8'hA5); send(8'h02); send(8'h11);
    idle(TO - 1);
    chk("timeout_early", err_timeout, 1'b0);
    idle(1);
    chk("timeout_pulse", err_timeout, 1'b1);
    idle(1);
    chk("timeout_single", err_timeout, 1'b0);

    // Byte on the terminal-count cycle wins; then overrun while held.
    send(8'hA5); send(8'h02); send(8'h11);
    idle(TO - 1);
    send(8'h22);
    chk("term_byte_no_timeout", err_timeout, 1'b0);
    send(8'h31);
    chk("term_frame_valid", frame_valid, 1'b1);
    chk("term_frame_data", frame_data, 64'h2211);
    idle(2);
    send(8'h5A);
    chk("overrun_pulse", err_overrun, 1'b1);
    chk("overrun_data_kept", frame_data, 64'h2211);
    chk("overrun_still_valid", frame_valid, 1'b1);
    idle(1);
    frame_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
    tick();
    frame_ready = 1'b0; rx_valid = 1'b0;
    chk("accept_overrun", err_overrun, 1'b1);
    chk("accept_drop_valid", frame_valid, 1'b0);
    idle(1);

    // Reset mid-payload, then a good frame.
    send(8'hA5); send(8'h03); send(8'h11);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_len", frame_len, 4'd0);
    chk("midrst_data", frame_data, 64'd0);
    tick();
    send_good_frame();
    chk("post_rst_valid", frame_valid, 1'b1);
    chk("post_rst_data", frame_data, 64'h332211);
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;

    // BREAK aborts silently; enable drop aborts silently.
    send(8'hA5); send(8'h03);
    rx_break = 1'b1; send(8'h11); rx_break = 1'b0;
    chk("break_silent", err_crc | err_len | err_timeout, 1'b0);
    send(8'h22); send(8'h33); send(8'h03);
    chk("break_no_frame", frame_valid, 1'b0);
    send(8'hA5); send(8'h03); send(8'h11);
    enable = 1'b0; tick(); enable = 1'b1;
    send(8'h22); send(8'h33); send(8'h03);
    chk("disable_no_frame", frame_valid, 1'b0);
    send_good_frame();
    chk("after_abort_valid", frame_valid, 1'b1);
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;

    // Randomized frames against the model.
    for (int f = 0; f < 400; f++) begin
      frm.delete();
      if ($urandom_range(0, 9) == 0) frm.push_back(8'($urandom_range(0, 255)));
      frm.push_back(SOF);
      case ($urandom_range(0, 19))
        0:       len = 0;
        1:       len = $urandom_range(9, 15);
        default: len = $urandom_range(1, MAX_LEN);
      endcase
      frm.push_back(8'(len));
      if (len >= 1 && len <= MAX_LEN) begin
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          frm.push_back(b);
          x ^= b;
        end
        if ($urandom_range(0, 9) == 0) x ^= 8'(1 << $urandom_range(0, 7));
        frm.push_back(x);
      end
      foreach (frm[i]) begin
        gap = ($urandom_range(0, 19) == 0) ? (TO - 1 + $urandom_range(0, 2)) : $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          rx_data = 8'($urandom_range(0, 255));
          frame_ready = ($urandom_range(0, 3) == 0);
          enable = ($urandom_range(0, 199) != 0);
          tick();
        end
        rx_break = ($urandom_range(0, 49) == 0);
        enable = ($urandom_range(0, 99) != 0);
        frame_ready = ($urandom_range(0, 3) == 0);
        send(frm[i]);
        rx_break = 1'b0; enable = 1'b1;
      end
      for (int g = 0; g < 3; g++) begin
        frame_ready = ($urandom_range(0, 1) == 0);
        tick();
      end
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
    end
    frame_ready = 1'b1; idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
